// File: rtl/conv_host_sequencer_pkg.sv
// Shared definitions for the convolution host sequencer.
// Holds the sequencer state encoding and the default widths shared with the
// convolution address FSM.
package conv_host_sequencer_pkg;

    localparam int DEF_NB_IMAGE   = 10;
    localparam int DEF_NB_ADDRESS = 10;

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        LD_ARM   = 4'd1,
        LD_STB   = 4'd2,
        LD_GAP   = 4'd3,
        LD_TERM  = 4'd4,
        LD_WAIT  = 4'd5,
        PROC     = 4'd6,
        PROC_END = 4'd7,
        DR_STB   = 4'd8,
        DR_WAIT  = 4'd9,
        DR_OUT   = 4'd10,
        DR_TERM  = 4'd11,
        DR_CBW   = 4'd12,
        DONE     = 4'd13
    } seq_state_t;

endpackage

// File: rtl/conv_host_sequencer_strobe_gen.sv
// conv_strobe_gen: issues one valid pulse (1 cycle high, then at least 1 cycle
// low) per request. Shared by the load and drain paths of the sequencer.
// Ports:
//   i_CLK, i_reset : clock, synchronous active-high reset
//   i_req          : request a strobe; taken whenever the strobe is not high
//   o_valid        : strobe to the FSM (high the cycle after the request)
//   o_done         : high in the low cycle that closes a strobe
module conv_strobe_gen (
    input  logic i_CLK,
    input  logic i_reset,
    input  logic i_req,
    output logic o_valid,
    output logic o_done
);

    logic strobeHigh;
    logic strobeGap;

    // A request while high is dropped, so a low cycle always follows a strobe.
    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            strobeHigh <= 1'b0;
            strobeGap  <= 1'b0;
        end else begin
            strobeHigh <= i_req & ~strobeHigh;
            strobeGap  <= strobeHigh;
        end
    end

    assign o_valid = strobeHigh;
    assign o_done  = strobeGap;

endmodule

// File: rtl/conv_host_sequencer.sv
// conv_host_sequencer: host-side driver of the convolution address FSM.
// One job per start: load L+1 pixels (plus a terminal strobe), hand the block
// to the FSM for processing, then drain L+1 results back to the host.
// Ports:
//   i_CLK, i_reset               : clock, synchronous active-high reset
//   i_start, i_imgLength         : job start (IDLE only), block length L
//   i_pix_valid/i_pix_data/o_pix_ready : host pixel stream in
//   o_pixel                      : pixel presented to the memory write port
//   o_load, o_SoP, o_valid       : FSM control pins
//   i_EoP, i_changeBlock         : FSM status
//   i_rdData                     : memory read data
//   o_res_data/o_res_valid/i_res_ready : result stream to host
//   o_busy, o_done               : job status
//   o_dbgState                   : current sequencer state
// Streams: a word moves in any cycle where valid and ready are both high;
// valid-side data holds steady until that cycle, and either side may stall.
module conv_host_sequencer
    import conv_host_sequencer_pkg::*;
#(
    parameter int NB_IMAGE  = DEF_NB_IMAGE,
    parameter int NB_DATA   = 8,
    parameter int NB_RESULT = 13,
    parameter int RD_LAT    = 2
) (
    input  logic                 i_CLK,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic [NB_IMAGE-1:0]  i_imgLength,
    input  logic                 i_pix_valid,
    input  logic [NB_DATA-1:0]   i_pix_data,
    output logic                 o_pix_ready,
    output logic [NB_DATA-1:0]   o_pixel,
    output logic                 o_load,
    output logic                 o_SoP,
    output logic                 o_valid,
    input  logic                 i_EoP,
    input  logic                 i_changeBlock,
    input  logic [NB_RESULT-1:0] i_rdData,
    output logic [NB_RESULT-1:0] o_res_data,
    output logic                 o_res_valid,
    input  logic                 i_res_ready,
    output logic                 o_busy,
    output logic                 o_done,
    output seq_state_t           o_dbgState
);

    // One extra bit so N = 2^NB_IMAGE is representable.
    localparam int CW = NB_IMAGE + 1;
    localparam int LW = $clog2(RD_LAT + 1);

    seq_state_t      state;
    seq_state_t      stateNext;
    logic [CW-1:0]   lenN;
    logic [CW-1:0]   pixCnt;
    logic [CW-1:0]   resCnt;
    logic [LW-1:0]   latCnt;
    logic            strobeReq;
    logic            strobeDone;
    logic            latDone;
    logic            lastResult;

    conv_strobe_gen u_strobe (
        .i_CLK   (i_CLK),
        .i_reset (i_reset),
        .i_req   (strobeReq),
        .o_valid (o_valid),
        .o_done  (strobeDone)
    );

    // Read data is valid RD_LAT cycles after the strobe cycle; DR_WAIT is
    // entered one cycle after it, so capture when latCnt reaches RD_LAT-1.
    assign latDone    = (latCnt == LW'(RD_LAT - 1));
    assign lastResult = ((resCnt + CW'(1)) == lenN);

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_reset) begin
            lenN       <= '0;
            pixCnt     <= '0;
            resCnt     <= '0;
            latCnt     <= '0;
            o_pixel    <= '0;
            o_res_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        lenN   <= {1'b0, i_imgLength} + CW'(1);
                        pixCnt <= '0;
                        resCnt <= '0;
                    end
                end
                LD_ARM:  if (o_pix_ready && i_pix_valid) o_pixel <= i_pix_data;
                LD_STB:  pixCnt <= pixCnt + CW'(1);
                DR_STB:  latCnt <= '0;
                DR_WAIT: begin
                    if (latDone) o_res_data <= i_rdData;
                    else         latCnt     <= latCnt + LW'(1);
                end
                DR_OUT:  if (i_res_ready) resCnt <= resCnt + CW'(1);
                DR_CBW:  if (i_changeBlock && i_EoP) resCnt <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext = state;
        strobeReq = 1'b0;
        case (state)
            IDLE:    if (i_start) stateNext = LD_ARM;
            LD_ARM: begin
                if (pixCnt == lenN) begin
                    strobeReq = 1'b1;
                    stateNext = LD_TERM;
                end else if (i_pix_valid) begin
                    strobeReq = 1'b1;
                    stateNext = LD_STB;
                end
            end
            LD_STB:  stateNext = LD_GAP;
            LD_GAP:  if (strobeDone) stateNext = LD_ARM;
            LD_TERM: stateNext = LD_WAIT;
            LD_WAIT: if (i_changeBlock) stateNext = PROC;
            PROC:    if (i_EoP) stateNext = PROC_END;
            PROC_END: begin
                if (i_EoP) begin
                    strobeReq = 1'b1;
                    stateNext = DR_STB;
                end else begin
                    stateNext = DONE;
                end
            end
            DR_STB:  stateNext = DR_WAIT;
            DR_WAIT: if (latDone) stateNext = DR_OUT;
            DR_OUT: begin
                if (i_res_ready) begin
                    strobeReq = 1'b1;
                    stateNext = lastResult ? DR_TERM : DR_STB;
                end
            end
            DR_TERM: stateNext = DR_CBW;
            DR_CBW: begin
                // EoP still high means another convolution over the same block.
                if (i_changeBlock) begin
                    if (i_EoP) begin
                        strobeReq = 1'b1;
                        stateNext = DR_STB;
                    end else begin
                        stateNext = DONE;
                    end
                end
            end
            DONE:    stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    assign o_load      = (state == LD_ARM) || (state == LD_STB) || (state == LD_GAP) ||
                         (state == LD_TERM) || (state == LD_WAIT);
    assign o_SoP       = (state == PROC);
    assign o_pix_ready = (state == LD_ARM) && (pixCnt != lenN);
    assign o_res_valid = (state == DR_OUT);
    assign o_busy      = (state != IDLE);
    assign o_done      = (state == DONE);
    assign o_dbgState  = state;

endmodule

// File: tb/tb_conv_host_sequencer.sv
module tb_conv_host_sequencer;
    import conv_host_sequencer_pkg::*;

    localparam int NB_IMAGE  = 10;
    localparam int NB_DATA   = 8;
    localparam int NB_RESULT = 13;
    localparam int RD_LAT    = 2;
    localparam logic [NB_RESULT-1:0] RES_BASE = 13'h100;
    localparam logic [NB_RESULT-1:0] RD_JUNK  = 13'h1ABC;

    logic                 i_CLK;
    logic                 i_reset;
    logic                 i_start;
    logic [NB_IMAGE-1:0]  i_imgLength;
    logic                 i_pix_valid;
    logic [NB_DATA-1:0]   i_pix_data;
    logic                 o_pix_ready;
    logic [NB_DATA-1:0]   o_pixel;
    logic                 o_load;
    logic                 o_SoP;
    logic                 o_valid;
    logic                 i_EoP;
    logic                 i_changeBlock;
    logic [NB_RESULT-1:0] i_rdData;
    logic [NB_RESULT-1:0] o_res_data;
    logic                 o_res_valid;
    logic                 i_res_ready;
    logic                 o_busy;
    logic                 o_done;
    seq_state_t           o_dbgState;

    conv_host_sequencer #(
        .NB_IMAGE (NB_IMAGE),
        .NB_DATA  (NB_DATA),
        .NB_RESULT(NB_RESULT),
        .RD_LAT   (RD_LAT)
    ) dut (
        .i_CLK        (i_CLK),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_imgLength  (i_imgLength),
        .i_pix_valid  (i_pix_valid),
        .i_pix_data   (i_pix_data),
        .o_pix_ready  (o_pix_ready),
        .o_pixel      (o_pixel),
        .o_load       (o_load),
        .o_SoP        (o_SoP),
        .o_valid      (o_valid),
        .i_EoP        (i_EoP),
        .i_changeBlock(i_changeBlock),
        .i_rdData     (i_rdData),
        .o_res_data   (o_res_data),
        .o_res_valid  (o_res_valid),
        .i_res_ready  (i_res_ready),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_dbgState   (o_dbgState)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        i_CLK = 1'b0;
        forever #5 i_CLK = ~i_CLK;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [NB_RESULT-1:0] exp_q[$];
    logic [NB_DATA-1:0]   pix_exp_q[$];
    logic [NB_DATA-1:0]   pixTbl[0:15];
    bit feedAbort;
    bit feedTimeout;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, want);
        end
    endtask

    // ---------------- bus monitor (owns its counters) ----------------
    int loadEdges = 0, drainEdges = 0, accCnt = 0, doneCnt = 0;
    int widthViol = 0, procViol = 0, overlapViol = 0;
    logic [NB_DATA-1:0] pixObs[0:255];
    int                 pixAcc[0:255];
    bit prevValid;

    initial begin
        prevValid = 1'b0;
        forever begin
            @(negedge i_CLK);
            if (o_pix_ready && i_pix_valid) accCnt++;
            if (o_valid && prevValid) widthViol++;
            if (o_valid && o_SoP) procViol++;
            if (o_load && o_SoP) overlapViol++;
            if (o_done) doneCnt++;
            if (o_valid && !prevValid) begin
                if (o_load) begin
                    if (loadEdges < 256) begin
                        pixObs[loadEdges] = o_pixel;
                        pixAcc[loadEdges] = accCnt;
                    end
                    loadEdges++;
                end else begin
                    drainEdges++;
                end
            end
            prevValid = o_valid;
        end
    end

    // ---------------- memory read model ----------------
    initial begin
        int memIdx, pendIdx, memCnt;
        memIdx = 0; pendIdx = 0; memCnt = 0;
        i_rdData = '0;
        forever begin
            @(posedge i_CLK);
            #1;
            if (o_SoP) memIdx = 0;
            if (memCnt > 0) begin
                memCnt--;
                if (memCnt == 0) i_rdData = RES_BASE + NB_RESULT'(pendIdx);
            end
            if (o_valid && !o_load) begin
                i_rdData = RD_JUNK;
                memCnt   = RD_LAT;
                pendIdx  = memIdx;
                memIdx++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic feed_pixels(input int n, input int gapMode);
        int to, gap;
        for (int k = 0; k < n; k++) begin
            i_pix_data  = pixTbl[k];
            i_pix_valid = 1'b1;
            to = 0;
            do begin
                @(negedge i_CLK);
                if (feedAbort) return;
                to++;
            end while (!o_pix_ready && to < 300);
            if (!o_pix_ready) begin
                feedTimeout = 1'b1;
                i_pix_valid = 1'b0;
                return;
            end
            pix_exp_q.push_back(pixTbl[k]);
            @(posedge i_CLK);
            #1;
            gap = (gapMode < 0) ? int'($urandom_range(0, 2)) : gapMode;
            if (gap > 0) begin
                i_pix_valid = 1'b0;
                repeat (gap) @(posedge i_CLK);
                #1;
            end
        end
        i_pix_valid = 1'b0;
    endtask

    task automatic pulse_start(input int len);
        @(posedge i_CLK);
        #1;
        i_imgLength = NB_IMAGE'(len);
        i_start     = 1'b1;
        @(posedge i_CLK);
        #1;
        i_start = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_load"},  o_load, 0);
        check({tag, "_sop"},   o_SoP, 0);
        check({tag, "_valid"}, o_valid, 0);
        check({tag, "_prdy"},  o_pix_ready, 0);
        check({tag, "_pixel"}, o_pixel, 0);
        check({tag, "_rvld"},  o_res_valid, 0);
        check({tag, "_rdata"}, o_res_data, 0);
        check({tag, "_busy"},  o_busy, 0);
        check({tag, "_done"},  o_done, 0);
        check({tag, "_state"}, o_dbgState, IDLE);
    endtask

    task automatic run_job(input int len, input int gapMode, input int stallIdx,
                           input bit midStart, input bit useTbl);
        int n, le0, acc0, de0, dn0, to, loadDrop, snapE;
        logic [NB_RESULT-1:0] snap;
        bit stable;
        n = len + 1;
        if (!useTbl) for (int k = 0; k < n; k++) pixTbl[k] = NB_DATA'($urandom_range(0, 255));
        for (int k = 0; k < n; k++) exp_q.push_back(RES_BASE + NB_RESULT'(k));
        le0 = loadEdges; acc0 = accCnt; de0 = drainEdges; dn0 = doneCnt;
        feedTimeout = 1'b0;
        loadDrop = 0;
        pulse_start(len);
        check("start_busy", o_busy, 1);

        // load phase
        fork
            feed_pixels(n, gapMode);
            begin
                to = 0;
                while ((loadEdges - le0) < n + 1 && to < 2000) begin
                    @(negedge i_CLK);
                    #1;
                    if (!o_load) loadDrop++;
                    to++;
                end
            end
        join
        check("feed_timeout", feedTimeout, 0);
        check("load_strobes", loadEdges - le0, n + 1);
        check("load_held", loadDrop, 0);
        for (int k = 0; k < n; k++) begin
            check("pixel", pixObs[le0 + k], pix_exp_q.pop_front());
            check("strobe_after_accept", pixAcc[le0 + k], acc0 + k + 1);
        end
        check("term_strobe_acc", pixAcc[le0 + n], acc0 + n);
        pix_exp_q.delete();

        // FSM swaps block -> processing
        @(posedge i_CLK); #1; i_changeBlock = 1'b1;
        @(posedge i_CLK); #1; i_changeBlock = 1'b0;
        @(negedge i_CLK);
        check("load_drop", o_load, 0);
        check("sop_rise", o_SoP, 1);
        for (int c = 0; c < 20; c++) begin
            @(posedge i_CLK);
            #1;
            i_start = midStart && (c == 5);
        end
        i_EoP = 1'b1;
        @(negedge i_CLK);
        @(negedge i_CLK);
        check("sop_drop", o_SoP, 0);
        check("drain_gap", o_valid, 0);
        @(negedge i_CLK);
        check("drain_first", o_valid, 1);

        // drain phase
        for (int k = 0; k < n; k++) begin
            to = 0;
            while (!o_res_valid && to < 100) begin
                @(negedge i_CLK);
                to++;
            end
            check("res_valid", o_res_valid, 1);
            if (k == stallIdx) begin
                snap = o_res_data; snapE = drainEdges; stable = 1'b1;
                repeat (10) begin
                    @(negedge i_CLK);
                    if (o_res_data !== snap || !o_res_valid) stable = 1'b0;
                end
                check("stall_stable", stable, 1);
                check("stall_no_strobe", drainEdges - snapE, 0);
            end
            @(posedge i_CLK); #1; i_res_ready = 1'b1;
            @(negedge i_CLK);
            check("res_data", o_res_data, exp_q.pop_front());
            @(posedge i_CLK); #1; i_res_ready = 1'b0;
        end
        to = 0;
        while ((drainEdges - de0) < n + 1 && to < 500) begin
            @(negedge i_CLK);
            #1;
            to++;
        end
        check("drain_strobes", drainEdges - de0, n + 1);
        @(posedge i_CLK); #1; i_changeBlock = 1'b1; i_EoP = 1'b0;
        @(posedge i_CLK); #1; i_changeBlock = 1'b0;
        repeat (4) @(negedge i_CLK);
        check("done_pulses", doneCnt - dn0, 1);
        check("end_busy", o_busy, 0);
        check("end_state", o_dbgState, IDLE);
        check("res_q_empty", exp_q.size(), 0);
        exp_q.delete();
        check("strobe_width", widthViol, 0);
        check("valid_in_proc", procViol, 0);
        check("load_sop_overlap", overlapViol, 0);
    endtask

    task automatic reset_mid_load();
        int le0, to;
        le0 = loadEdges;
        for (int k = 0; k < 4; k++) pixTbl[k] = NB_DATA'($urandom_range(0, 255));
        feedAbort = 1'b0;
        pulse_start(3);
        fork
            feed_pixels(4, 0);
        join_none
        to = 0;
        while ((loadEdges - le0) < 2 && to < 200) begin
            @(negedge i_CLK);
            #1;
            to++;
        end
        @(posedge i_CLK);
        #1;
        check("pre_reset_gap", o_dbgState, LD_GAP);
        i_reset   = 1'b1;
        feedAbort = 1'b1;
        @(posedge i_CLK);
        #1;
        i_reset = 1'b0;
        @(negedge i_CLK);
        check_idle("abort");
        repeat (3) @(negedge i_CLK);
        i_pix_valid = 1'b0;
        feedAbort   = 1'b0;
        pix_exp_q.delete();
        repeat (3) @(negedge i_CLK);
        check("abort_strobes", loadEdges - le0, 2);
        check("abort_idle", o_busy, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_imgLength = '0;
        i_pix_valid = 1'b0; i_pix_data = '0;
        i_EoP = 1'b0; i_changeBlock = 1'b0; i_res_ready = 1'b0;
        feedAbort = 1'b0; feedTimeout = 1'b0;
        repeat (3) @(posedge i_CLK);
        @(negedge i_CLK);
        check_idle("reset");
        @(posedge i_CLK);
        #1;
        i_reset = 1'b0;

        // L=3, fixed pixels back-to-back, host stalls the 2nd result
        pixTbl[0] = 8'h11; pixTbl[1] = 8'h22; pixTbl[2] = 8'h33; pixTbl[3] = 8'h44;
        run_job(3, 0, 1, 1'b0, 1'b1);
        // L=5, host pixel valid once every 4th cycle
        run_job(5, 3, -1, 1'b0, 1'b0);
        // reset in LD_GAP after two strobes, then a clean L=1 job
        reset_mid_load();
        run_job(1, -1, -1, 1'b0, 1'b0);
        // L=0 with a stray start during processing
        run_job(0, 0, 0, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_host_sequencer.md
Name: conv_host_sequencer

Overview:
- Host-side driver for the convolution address FSM. It runs one full job per start: load one image block into memory, trigger processing, then drain the processed block back to the host.
- Generates the FSM control pins (load, SoP, valid-strobe) and consumes its status (EoP, changeBlock).
- Sits between the host GPIO/stream interface and the FSM/memory bank.

Parameters:
- NB_IMAGE, 10, width of image length / pixel counter
- NB_DATA, 8, width of input pixel word
- NB_RESULT, 13, width of result word read back from memory
- RD_LAT, 2, cycles from valid-strobe rising edge to valid i_rdData

Ports:
- i_CLK  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_start  in  1  start-job pulse, honoured only in IDLE
- i_imgLength  in  NB_IMAGE  block length L; sampled on accepted start
- i_pix_valid  in  1  host pixel available
- i_pix_data  in  NB_DATA  host pixel
- o_pix_ready  out  1  sequencer accepts pixel this cycle
- o_pixel  out  NB_DATA  pixel presented to memory write port
- o_load  out  1  to FSM i_load
- o_SoP  out  1  to FSM i_SoP
- o_valid  out  1  to FSM i_valid (strobe)
- i_EoP  in  1  from FSM o_EoP
- i_changeBlock  in  1  from FSM o_changeBlock
- i_rdData  in  NB_RESULT  memory read data
- o_res_data  out  NB_RESULT  result to host
- o_res_valid  out  1  result available
- i_res_ready  in  1  host accepts result
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at job end

Behaviour:
- Reset: state IDLE; all outputs 0; pixel and result counters 0. Reset mid-job aborts immediately to this condition, with no further strobes.
- L is latched at start; N = L+1 data strobes per block, plus one terminal strobe. The terminal strobe makes the FSM assert changeBlock.
- Strobe rule: o_valid is high for exactly 1 cycle, then low for ≥1 cycle. The FSM counts rising edges only.
- IDLE: i_start=1 → LD_ARM, with o_load=1. o_load is held through the whole load phase.
- LD_ARM:
  - o_pix_ready=1.
  - On i_pix_valid, register i_pix_data into o_pixel → LD_STB.
  - If pix_cnt==N instead, → LD_TERM (o_pix_ready=0).
- LD_STB: o_valid=1; pix_cnt++ → LD_GAP.
- LD_GAP: o_valid=0 → LD_ARM.
- Pixel timing: an accepted pixel strobes 1 cycle later. Minimum pixel period is 3 cycles.
- o_pixel holds its value until the next acceptance.
- LD_TERM: one strobe (valid 1 cycle, then low) → LD_WAIT.
- LD_WAIT:
  - On i_changeBlock=1: o_load=0 next cycle, → PROC.
  - Strobes are suppressed while waiting.
- PROC: o_SoP=1; wait for i_EoP=1 → PROC_END.
- PROC_END:
  - o_SoP=0 for 1 cycle.
  - If i_EoP is still 1 → DR_STB; else → DONE.
- DR_STB: o_valid=1 for 1 cycle → DR_WAIT.
- DR_WAIT:
  - o_valid=0; count RD_LAT-1 cycles.
  - Capture i_rdData into o_res_data → DR_OUT.
- DR_OUT:
  - o_res_valid=1 and o_res_data stable until i_res_ready.
  - On the handshake: res_cnt++.
  - If res_cnt==N → DR_TERM; else → DR_STB.
- DR_TERM: terminal strobe → DR_CBW; wait for i_changeBlock.
- DR_CBW exit:
  - If i_EoP is still 1 (multi-conv), clear res_cnt → DR_STB.
  - Else → DONE.
- DONE: o_done=1 for 1 cycle → IDLE.
- Host backpressure: i_pix_valid low or i_res_ready low stalls indefinitely. No strobe is issued during a stall.
- i_start outside IDLE is ignored.
- L=0 is legal: 1 data strobe plus 1 terminal strobe.
- Counters are NB_IMAGE+1 bits wide to hold N=2^NB_IMAGE without wrap.
- o_load and o_SoP are never high simultaneously. o_valid is never high in PROC.

Decomposition:
- Shared package:
  - state encoding localparams (IDLE, LD_ARM, LD_STB, LD_GAP, LD_TERM, LD_WAIT, PROC, PROC_END, DR_STB, DR_WAIT, DR_OUT, DR_TERM, DR_CBW, DONE);
  - default widths `NB_IMAGE` and `NB_ADDRESS`, shared with the FSM.
- Sub-module: conv_strobe_gen, which issues a single 1-high/1-low valid pulse on request and returns a done flag. It is used by both the load and drain paths.

Test Plan:
- L=3, host pixels 0x11,0x22,0x33,0x44 back-to-back → o_pixel sequence matches; 5 o_valid rising edges, each 1 cycle wide with ≥1 low cycle between; o_load high throughout; model FSM asserts changeBlock → o_load drops, o_SoP rises.
- Process phase: model EoP asserted 20 cycles after SoP → o_SoP low the next cycle; first drain strobe 1 cycle later; zero o_valid edges during PROC.
- Drain, L=3, RD_LAT=2, memory returns 0x100..0x103 → o_res_data yields 0x100..0x103 in order; with i_res_ready held low 10 cycles on the 2nd result, no strobe is issued and data stays stable; o_done pulses once after changeBlock.
- i_pix_valid toggling every 4th cycle → strobe count is still exactly L+2; no strobe without an accepted pixel except the terminal strobe.
- i_reset asserted in LD_GAP with pix_cnt=2 → next cycle all outputs 0, state IDLE; new i_start with L=1 runs a clean job with 3 load strobes.
- L=0 and i_start asserted during PROC → 2 load strobes, 2 drain strobes; the mid-job start has no effect.
